// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result valid-ready bundle between the execute stage and alu_mc.
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      alu_ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, A, B, alu_ctrl, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, A, B, alu_ctrl, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I ALU behind a valid/ready handshake, registered result and zero.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide datapath (codes 10-14).
module alu_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    alu_mc_if.slave bus
);

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    localparam logic [XLEN-1:0] ALL_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic [XLEN-1:0] fast_result_s;

`ifdef ALU_MULDIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  acc_r;
    logic [XLEN-1:0]  mq_r;
    logic [XLEN-1:0]  mcand_r;
    logic             mul_r;
    logic             rem_r;
    logic             neg_r;

    logic             start_iter_s;
    logic             div_signed_s;
    logic             overflow_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [XLEN-1:0]  a_mag_s;
    logic [XLEN-1:0]  b_mag_s;
    logic [XLEN:0]    rem_shift_s;
    logic [XLEN:0]    diff_s;
    logic [XLEN-1:0]  acc_nx_s;
    logic [XLEN-1:0]  mq_nx_s;
    logic [XLEN-1:0]  mcand_nx_s;
    logic [XLEN-1:0]  final_s;
`endif

    function automatic logic [XLEN-1:0] single_op(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            4'd0:    single_op = a + b;
            4'd1:    single_op = a - b;
            4'd2:    single_op = a & b;
            4'd3:    single_op = a | b;
            4'd4:    single_op = a ^ b;
            4'd5:    single_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    single_op = a << sh;
            4'd7:    single_op = a >> sh;
            4'd8:    single_op = {{(XLEN-1){1'b0}}, (a < b)};
            4'd9:    single_op = $signed(a) >>> sh;
            default: single_op = ALL_ZERO;
        endcase
    endfunction

    // Accept-edge result: single-cycle ops and divide corner cases; flags ops that must iterate.
    always_comb begin
        fast_result_s = single_op(bus.alu_ctrl, bus.A, bus.B);
`ifdef ALU_MULDIV_EN
        start_iter_s = 1'b0;
        div_signed_s = (bus.alu_ctrl == 4'd11) || (bus.alu_ctrl == 4'd13);
        a_neg_s      = div_signed_s & bus.A[XLEN-1];
        b_neg_s      = div_signed_s & bus.B[XLEN-1];
        a_mag_s      = a_neg_s ? (ALL_ZERO - bus.A) : bus.A;
        b_mag_s      = b_neg_s ? (ALL_ZERO - bus.B) : bus.B;
        overflow_s   = div_signed_s && (bus.A == MOST_NEG) && (bus.B == ALL_ONES);
        case (bus.alu_ctrl)
            4'd10: start_iter_s = 1'b1;
            4'd11, 4'd12: begin
                if (bus.B == ALL_ZERO) begin
                    fast_result_s = ALL_ONES;
                end else if (overflow_s) begin
                    fast_result_s = bus.A;
                end else begin
                    start_iter_s = 1'b1;
                end
            end
            4'd13, 4'd14: begin
                if (bus.B == ALL_ZERO) begin
                    fast_result_s = bus.A;
                end else if (overflow_s) begin
                    fast_result_s = ALL_ZERO;
                end else begin
                    start_iter_s = 1'b1;
                end
            end
            default: start_iter_s = 1'b0;
        endcase
`endif
    end

`ifdef ALU_MULDIV_EN
    // One radix-2 step: shift-add multiply, or restoring divide on magnitudes with final sign fix.
    always_comb begin
        rem_shift_s = {acc_r, mq_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, mcand_r};
        if (mul_r) begin
            acc_nx_s   = acc_r + (mq_r[0] ? mcand_r : ALL_ZERO);
            mq_nx_s    = mq_r >> 1;
            mcand_nx_s = mcand_r << 1;
        end else begin
            mcand_nx_s = mcand_r;
            // diff_s[XLEN] is the borrow: set when the divisor does not fit.
            if (!diff_s[XLEN]) begin
                acc_nx_s = diff_s[XLEN-1:0];
                mq_nx_s  = {mq_r[XLEN-2:0], 1'b1};
            end else begin
                acc_nx_s = rem_shift_s[XLEN-1:0];
                mq_nx_s  = {mq_r[XLEN-2:0], 1'b0};
            end
        end
        if (mul_r) begin
            final_s = acc_nx_s;
        end else if (rem_r) begin
            final_s = neg_r ? (ALL_ZERO - acc_nx_s) : acc_nx_s;
        end else begin
            final_s = neg_r ? (ALL_ZERO - mq_nx_s) : mq_nx_s;
        end
    end
`endif

    // Handshake FSM with registered outputs and iteration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= ALL_ZERO;
            zero_r      <= 1'b1;
`ifdef ALU_MULDIV_EN
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= ALL_ZERO;
            mq_r        <= ALL_ZERO;
            mcand_r     <= ALL_ZERO;
            mul_r       <= 1'b0;
            rem_r       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (flush) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_r       <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
`ifdef ALU_MULDIV_EN
                        if (start_iter_s) begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_W'(XLEN);
                            acc_r   <= ALL_ZERO;
                            mul_r   <= (bus.alu_ctrl == 4'd10);
                            rem_r   <= (bus.alu_ctrl == 4'd13) || (bus.alu_ctrl == 4'd14);
                            neg_r   <= (bus.alu_ctrl == 4'd11) ? (a_neg_s ^ b_neg_s) : a_neg_s;
                            mq_r    <= (bus.alu_ctrl == 4'd10) ? bus.B : a_mag_s;
                            mcand_r <= (bus.alu_ctrl == 4'd10) ? bus.A : b_mag_s;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= fast_result_s;
                            zero_r      <= (fast_result_s == ALL_ZERO);
                        end
`else
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= fast_result_s;
                        zero_r      <= (fast_result_s == ALL_ZERO);
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    acc_r   <= acc_nx_s;
                    mq_r    <= mq_nx_s;
                    mcand_r <= mcand_nx_s;
                    cnt_r   <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= final_s;
                        zero_r      <= (final_s == ALL_ZERO);
                    end else begin
                        state_r <= BUSY;
                    end
                end
`endif
                DONE: begin
                    // in_ready returns only after the handoff cycle, never alongside it.
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle ALU.
- Executes the full RV32I integer op set. With the optional feature compiled in, it also executes iterative RV32M multiply/divide.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline can stall on long ops.
- Result and zero flag are registered and held until consumed.

Parameters:
- XLEN, 32, operand/result width; must be a power of two and at least 8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from B (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous abort of any in-flight or held op.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op.
- A  in  XLEN  operand A.
- B  in  XLEN  operand B.
- alu_ctrl  in  4  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous, active-high; it is sampled on the clk rising edge and overrides every other input.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, all iteration registers 0.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLL, 7 SRL, 8 SLTU (unsigned), 9 SRA (arithmetic).
  - 10 MUL (low XLEN of product), 11 DIV, 12 DIVU, 13 REM, 14 REMU.
  - 15 and any disabled code return 0.
- Shifts use B[SHAMT_W-1:0] only. All arithmetic wraps modulo 2^XLEN.
- States:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) latches A, B and alu_ctrl.
    - Single-cycle op: result computed and registered at the accept edge; go to DONE.
    - Iterative op: go to BUSY with cnt=XLEN.
  - BUSY: in_ready=0. One radix-2 step per cycle (MUL shift-add; DIV/REM restoring on magnitudes, sign fixed at end). cnt decrements; at cnt==1, register the final result and go to DONE.
  - DONE: out_valid=1, in_ready=0. result and zero are stable. When out_ready=1, go to IDLE with out_valid=0 next cycle.
- Latency:
  - Single-cycle op: out_valid high on the cycle after the accept edge.
  - Iterative op: out_valid high XLEN+1 cycles after the accept edge.
- No new op is accepted in the same cycle as a result handoff; in_ready rises only the cycle after DONE exits. Throughput is therefore one single-cycle op per 2 cycles.
- Divide corner cases (resolved at the accept edge, no BUSY phase, 1-cycle latency):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = A.
  - Signed overflow (A = most-negative, B = -1): DIV = A, REM = 0.
- Signed DIV/REM:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- flush: next state IDLE, out_valid=0, iteration aborted, result unchanged. If flush and in_valid are asserted together in IDLE, the op is discarded.
- rst mid-BUSY or in DONE: immediate return to reset values at that edge.
- in_valid while in_ready=0 is ignored; operands need not be held.
- zero is always registered together with result.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: codes 10-14 behave as above.
- Undefined:
  - Codes 10-14 are treated as unknown: result 0, zero=1, single-cycle latency.
  - BUSY state and iteration datapath are not built.

Test Plan:
- Reset, then ADD A=5, B=7, out_ready=1 -> out_valid on the cycle after accept, result=12, zero=0; in_ready back high one cycle later.
- SRA A=0x80000000, B=0x24; SLTU A=1, B=0xFFFFFFFF; SUB A=3, B=3 -> results 0xF8000000; 1; 0 with zero=1.
- (ALU_MULDIV_EN) MUL A=0xFFFFFFFF, B=3 -> 0xFFFFFFFD at accept+33 cycles; DIV A=-7, B=2 -> 0xFFFFFFFD; REM A=-7, B=2 -> 0xFFFFFFFF.
- (ALU_MULDIV_EN) DIVU A=9, B=0 -> 0xFFFFFFFF at 1-cycle latency; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: out_ready=0 for 5 cycles after ADD 1+1 -> result=2 held, in_ready=0 throughout; in_valid pulses during the stall are ignored.
- flush at cycle 10 of a DIVU, and rst mid-BUSY in a separate run -> IDLE next cycle with out_valid=0; a following ADD 2+2 returns 4 normally.
